// File: rtl/kp_pkg.sv
// Shared keypad definitions: emulator FSM states, key codes and the key-to-matrix-position table.
package kp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_PRESS,
        ST_HOLD,
        ST_BOUNCE_REL,
        ST_GAP
    } kp_state_e;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } kp_pos_t;

    // Matrix position of each key: rows 123A / 456B / 789C / *0#D.
    function automatic kp_pos_t key_pos(input logic [3:0] code);
        kp_pos_t p;
        p = '{row: 2'd3, col: 2'd1};
        case (code)
            KEY_1:    p = '{row: 2'd0, col: 2'd0};
            KEY_2:    p = '{row: 2'd0, col: 2'd1};
            KEY_3:    p = '{row: 2'd0, col: 2'd2};
            KEY_A:    p = '{row: 2'd0, col: 2'd3};
            KEY_4:    p = '{row: 2'd1, col: 2'd0};
            KEY_5:    p = '{row: 2'd1, col: 2'd1};
            KEY_6:    p = '{row: 2'd1, col: 2'd2};
            KEY_B:    p = '{row: 2'd1, col: 2'd3};
            KEY_7:    p = '{row: 2'd2, col: 2'd0};
            KEY_8:    p = '{row: 2'd2, col: 2'd1};
            KEY_9:    p = '{row: 2'd2, col: 2'd2};
            KEY_C:    p = '{row: 2'd2, col: 2'd3};
            KEY_STAR: p = '{row: 2'd3, col: 2'd0};
            KEY_0:    p = '{row: 2'd3, col: 2'd1};
            KEY_HASH: p = '{row: 2'd3, col: 2'd2};
            KEY_D:    p = '{row: 2'd3, col: 2'd3};
            default:  p = '{row: 2'd3, col: 2'd1};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/kp_phase_timer.sv
// Phase window timer: cleared on each phase change, counts while enabled, flags the last cycle.
module kp_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_expire_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire_c = i_en && (r_cnt == i_last);

endmodule

// File: rtl/keypad_emulator.sv
// Matrix keypad stand-in: presses one requested key with press/release bounce, hold and gap,
// and answers the scanner's column drive through a combinational switch model.
module keypad_emulator
    import kp_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 16,
    parameter int unsigned BOUNCE_TOGGLE = 3,
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned GAP_CYCLES    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_BT = (BOUNCE_CYCLES > BOUNCE_TOGGLE) ? BOUNCE_CYCLES : BOUNCE_TOGGLE;
    localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_P  = (MAX_BT > MAX_HG) ? MAX_BT : MAX_HG;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;
    localparam int unsigned TOG_W  = $clog2(BOUNCE_TOGGLE) + 1;

    localparam bit               NO_BOUNCE   = (BOUNCE_CYCLES == 0);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [TOG_W-1:0] TOG_LAST    = TOG_W'(BOUNCE_TOGGLE - 1);

    kp_state_e        r_state, w_next;
    logic [3:0]       r_key;
    logic             r_contact, w_contact_nxt;
    logic [TOG_W-1:0] r_tog, w_tog_nxt;
    logic             r_done, w_done_nxt;
    logic             w_accept, w_change, w_en, w_expire;
    logic [CNT_W-1:0] w_last;
    kp_pos_t          w_pos;

    assign w_accept = key_valid && (r_state == ST_IDLE);
    assign w_change = (w_next != r_state);

    kp_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_change),
        .i_en       (w_en),
        .i_last     (w_last),
        .o_expire_c (w_expire)
    );

    // Window length for the current phase; depends on state only.
    always_comb begin
        w_en   = 1'b1;
        w_last = '0;
        case (r_state)
            ST_BOUNCE_PRESS, ST_BOUNCE_REL: w_last = BOUNCE_LAST;
            ST_HOLD:                        w_last = HOLD_LAST;
            ST_GAP:                         w_last = GAP_LAST;
            default:                        w_en   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_key     <= '0;
            r_contact <= 1'b0;
            r_tog     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_contact <= w_contact_nxt;
            r_tog     <= w_tog_nxt;
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_key <= key_code;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_contact_nxt = 1'b0;
        w_tog_nxt     = '0;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE:         if (key_valid) w_next = NO_BOUNCE ? ST_HOLD : ST_BOUNCE_PRESS;
            ST_BOUNCE_PRESS: if (w_expire) w_next = ST_HOLD;
            ST_HOLD:         if (w_expire) w_next = NO_BOUNCE ? ST_GAP : ST_BOUNCE_REL;
            ST_BOUNCE_REL:   if (w_expire) w_next = ST_GAP;
            ST_GAP: begin
                if (w_expire) begin
                    w_next     = ST_IDLE;
                    w_done_nxt = 1'b1;
                end
            end
            default:         w_next = ST_IDLE;
        endcase

        // Contact starts closed on press bounce, open on release bounce, then chatters.
        if (w_next != r_state) begin
            w_contact_nxt = (w_next == ST_BOUNCE_PRESS) || (w_next == ST_HOLD);
        end else if ((r_state == ST_BOUNCE_PRESS) || (r_state == ST_BOUNCE_REL)) begin
            if (r_tog == TOG_LAST) begin
                w_contact_nxt = ~r_contact;
            end else begin
                w_contact_nxt = r_contact;
                w_tog_nxt     = r_tog + TOG_W'(1);
            end
        end else begin
            w_contact_nxt = (r_state == ST_HOLD);
        end
    end

    assign w_pos     = key_pos(r_key);
    assign row_out   = (r_contact && col_in[w_pos.col]) ? (4'b0001 << w_pos.row) : 4'b0000;
    assign key_ready = (r_state == ST_IDLE);
    assign busy      = !key_ready;
    assign done      = r_done;

endmodule
